// File: rtl/can_host_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// can_host_mailbox_pkg
// Shared types and defaults for the host-side CAN mailbox.
//   mbx_state_e : TX hand-off FSM states (IDLE / ISSUED / RETRY)
//   tx_entry_t  : one queued outgoing frame {id, dest, data}
//   satInc16    : 16-bit saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package can_host_mailbox_pkg;

  localparam int MBX_DATA_SIZE = 64;
  localparam int MBX_ID_SIZE   = 11;
  localparam int MBX_TX_DEPTH  = 4;
  localparam int MBX_RX_DEPTH  = 4;
  localparam int MBX_MAX_RETRY = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    RETRY  = 2'd2
  } mbx_state_e;

  typedef struct packed {
    logic [MBX_ID_SIZE-1:0]   id;
    logic [MBX_ID_SIZE-1:0]   dest;
    logic [MBX_DATA_SIZE-1:0] data;
  } tx_entry_t;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/can_msg_fifo.sv
// ---------------------------------------------------------------------------
// can_msg_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on rdata_o while empty_o is low. Pushes while full and pops while empty
// are ignored, so a push on a full FIFO is dropped even if a pop happens in
// the same cycle.
// Ports:
//   clock, reset         : clock, asynchronous active-low reset
//   push_i / wdata_i     : write request and data
//   pop_i                : remove head entry
//   rdata_o              : head entry
//   full_o / empty_o     : occupancy flags
// ---------------------------------------------------------------------------
module can_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; contents are only observable through the pointers.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/can_host_mailbox.sv
// ---------------------------------------------------------------------------
// can_host_mailbox
// Host-side mailbox beside a CAN node. The host queues outgoing frames; the
// node pulls one per data_in_req, reports failures with Retransmit (the same
// frame is re-presented on the next request, up to MAX_RETRY attempts) and
// delivers received payloads with data_out_req into an RX queue the host
// drains.
// Ports:
//   clock, reset                   : clock, asynchronous active-low reset
//   tx_valid/tx_ready, tx_id/dest/data : host push of outgoing frames
//   data_in_req, Retransmit        : node fetch / failure report
//   In_packet, Tx_ID, Rx_ID        : registered frame handed to the node
//   tx_avail                       : new or retry frame ready for the node
//   data_out_req, Rx_packet        : node delivers a received payload
//   rx_valid/rx_ready/rx_data      : host pop of received payloads (FWFT)
//   rx_overflow, rx_ovf_clr        : sticky RX drop flag and its clear
//   tx_done, tx_drop               : one-cycle outcome pulses
//   done_cnt, fail_cnt             : saturating success / Retransmit counts
// ---------------------------------------------------------------------------
module can_host_mailbox
  import can_host_mailbox_pkg::*;
#(
  parameter int DATA_SIZE = MBX_DATA_SIZE,
  parameter int ID_SIZE   = MBX_ID_SIZE,
  parameter int TX_DEPTH  = MBX_TX_DEPTH,
  parameter int RX_DEPTH  = MBX_RX_DEPTH,
  parameter int MAX_RETRY = MBX_MAX_RETRY
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [ID_SIZE-1:0]   tx_id,
  input  logic [ID_SIZE-1:0]   tx_dest,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 data_in_req,
  input  logic                 Retransmit,
  output logic [DATA_SIZE-1:0] In_packet,
  output logic [ID_SIZE-1:0]   Tx_ID,
  output logic [ID_SIZE-1:0]   Rx_ID,
  output logic                 tx_avail,
  input  logic                 data_out_req,
  input  logic [DATA_SIZE-1:0] Rx_packet,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_overflow,
  input  logic                 rx_ovf_clr,
  output logic                 tx_done,
  output logic                 tx_drop,
  output logic [15:0]          done_cnt,
  output logic [15:0]          fail_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  mbx_state_e     state_q;
  logic [RW-1:0]  retryCnt_q;

  tx_entry_t      txEntryIn;
  tx_entry_t      txHead;
  logic           txFull;
  logic           txEmpty;
  logic           txPop;
  logic           lastAttempt;

  logic [DATA_SIZE-1:0] rxHead;
  logic                 rxFull;
  logic                 rxEmpty;
  logic                 rxPop;

  assign txEntryIn = '{id: tx_id, dest: tx_dest, data: tx_data};

  can_msg_fifo #(
    .WIDTH ($bits(tx_entry_t)),
    .DEPTH (TX_DEPTH)
  ) u_txFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_valid),
    .wdata_i (txEntryIn),
    .pop_i   (txPop),
    .rdata_o (txHead),
    .full_o  (txFull),
    .empty_o (txEmpty)
  );

  assign tx_ready = !txFull;
  assign tx_avail = (state_q == RETRY) || !txEmpty;

  // A Retransmit that exhausts the attempt budget frees the FSM in the same
  // cycle, so a coincident data_in_req fetches the next queued frame.
  assign lastAttempt = (state_q == ISSUED) && Retransmit &&
                       (int'(retryCnt_q) + 1 == MAX_RETRY);
  assign txPop = data_in_req && !txEmpty &&
                 ((state_q == IDLE) ||
                  ((state_q == ISSUED) && (!Retransmit || lastAttempt)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      retryCnt_q <= '0;
      In_packet  <= '0;
      Tx_ID      <= '0;
      Rx_ID      <= '0;
      tx_done    <= 1'b0;
      tx_drop    <= 1'b0;
      done_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_drop <= 1'b0;
      if (txPop) begin
        In_packet  <= txHead.data;
        Tx_ID      <= txHead.id;
        Rx_ID      <= txHead.dest;
        retryCnt_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (txPop) state_q <= ISSUED;
        end
        ISSUED: begin
          if (Retransmit) begin
            fail_cnt <= satInc16(fail_cnt);
            if (lastAttempt) begin
              tx_drop <= 1'b1;
              state_q <= txPop ? ISSUED : IDLE;
            end else begin
              // Staging is kept; a coincident request re-issues it directly.
              retryCnt_q <= retryCnt_q + 1'b1;
              state_q    <= data_in_req ? ISSUED : RETRY;
            end
          end else if (data_in_req) begin
            tx_done  <= 1'b1;
            done_cnt <= satInc16(done_cnt);
            state_q  <= txPop ? ISSUED : IDLE;
          end
        end
        RETRY: begin
          if (data_in_req) state_q <= ISSUED;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  can_msg_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (RX_DEPTH)
  ) u_rxFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (data_out_req),
    .wdata_i (Rx_packet),
    .pop_i   (rxPop),
    .rdata_o (rxHead),
    .full_o  (rxFull),
    .empty_o (rxEmpty)
  );

  assign rxPop    = rx_ready && !rxEmpty;
  assign rx_valid = !rxEmpty;
  assign rx_data  = rxEmpty ? '0 : rxHead;

  // Fullness is judged before any same-cycle pop, so a delivery into a full
  // queue is always dropped; a set wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_overflow <= 1'b0;
    end else if (data_out_req && rxFull) begin
      rx_overflow <= 1'b1;
    end else if (rx_ovf_clr) begin
      rx_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_can_host_mailbox.sv
// ---------------------------------------------------------------------------
// tb_can_host_mailbox
// Directed scenarios followed by randomized traffic. A behavioural model of
// the mailbox (queues plus a small outcome-first state machine) predicts the
// outputs after every clock edge; a separate monitor pops those predictions
// and the expected RX payload stream and compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_can_host_mailbox;

  localparam int MAXR  = 8;
  localparam int TXD   = 4;
  localparam int RXD   = 4;
  localparam int S_IDLE   = 0;
  localparam int S_ISSUED = 1;
  localparam int S_RETRY  = 2;

  typedef struct packed {
    logic [10:0] id;
    logic [10:0] dest;
    logic [63:0] data;
  } frame_t;

  typedef struct {
    bit     txAvail;
    bit     txReady;
    bit     rxValid;
    bit     ovf;
    bit     txDone;
    bit     txDrop;
    int     doneCnt;
    int     failCnt;
    frame_t frame;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] tx_id;
  logic [10:0] tx_dest;
  logic [63:0] tx_data;
  logic        data_in_req;
  logic        Retransmit;
  logic [63:0] In_packet;
  logic [10:0] Tx_ID;
  logic [10:0] Rx_ID;
  logic        tx_avail;
  logic        data_out_req;
  logic [63:0] Rx_packet;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] rx_data;
  logic        rx_overflow;
  logic        rx_ovf_clr;
  logic        tx_done;
  logic        tx_drop;
  logic [15:0] done_cnt;
  logic [15:0] fail_cnt;

  can_host_mailbox dut (
    .clock        (clock),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_id        (tx_id),
    .tx_dest      (tx_dest),
    .tx_data      (tx_data),
    .data_in_req  (data_in_req),
    .Retransmit   (Retransmit),
    .In_packet    (In_packet),
    .Tx_ID        (Tx_ID),
    .Rx_ID        (Rx_ID),
    .tx_avail     (tx_avail),
    .data_out_req (data_out_req),
    .Rx_packet    (Rx_packet),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_overflow  (rx_overflow),
    .rx_ovf_clr   (rx_ovf_clr),
    .tx_done      (tx_done),
    .tx_drop      (tx_drop),
    .done_cnt     (done_cnt),
    .fail_cnt     (fail_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  frame_t      mTxQ[$];
  logic [63:0] mRxQ[$];
  int          mState;
  int          mAttempts;
  frame_t      mStaged;
  int          mDone;
  int          mFail;
  bit          mOvf;
  bit          mDoneEvt;
  bit          mDropEvt;

  // Scoreboard queues
  exp_t        expQ[$];
  logic [63:0] expRxData[$];
  exp_t        monE;

  int nCompared = 0;
  int nMismatch = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic modelReset();
    mTxQ.delete();
    mRxQ.delete();
    expRxData.delete();
    mState    = S_IDLE;
    mAttempts = 0;
    mStaged   = '0;
    mDone     = 0;
    mFail     = 0;
    mOvf      = 1'b0;
    mDoneEvt  = 1'b0;
    mDropEvt  = 1'b0;
  endtask

  // One clock edge of mailbox behaviour: settle the outcome of the frame in
  // flight first, then serve the request, then accept host/node pushes.
  task automatic modelStep();
    bit txFullPre;
    bit rxFullPre;
    bit rxHadData;
    txFullPre = (mTxQ.size() >= TXD);
    rxFullPre = (mRxQ.size() >= RXD);
    rxHadData = (mRxQ.size() > 0);
    mDoneEvt  = 1'b0;
    mDropEvt  = 1'b0;
    if (mState == S_ISSUED && Retransmit) begin
      mFail = sat16(mFail);
      mAttempts++;
      if (mAttempts == MAXR) begin
        mDropEvt = 1'b1;
        mState   = S_IDLE;
      end else begin
        mState = S_RETRY;
      end
    end else if (mState == S_ISSUED && data_in_req) begin
      mDoneEvt = 1'b1;
      mDone    = sat16(mDone);
      mState   = S_IDLE;
    end
    if (data_in_req) begin
      if (mState == S_RETRY) begin
        mState = S_ISSUED;
      end else if (mState == S_IDLE && mTxQ.size() > 0) begin
        mStaged   = mTxQ.pop_front();
        mAttempts = 0;
        mState    = S_ISSUED;
      end
    end
    if (tx_valid && !txFullPre) mTxQ.push_back({tx_id, tx_dest, tx_data});
    if (rx_ready && rxHadData) void'(mRxQ.pop_front());
    if (data_out_req && rxFullPre) begin
      mOvf = 1'b1;
    end else begin
      if (data_out_req) begin
        mRxQ.push_back(Rx_packet);
        expRxData.push_back(Rx_packet);
      end
      if (rx_ovf_clr) mOvf = 1'b0;
    end
  endtask

  task automatic pushExp();
    exp_t e;
    e.txAvail = (mState == S_RETRY) || (mTxQ.size() > 0);
    e.txReady = (mTxQ.size() < TXD);
    e.rxValid = (mRxQ.size() > 0);
    e.ovf     = mOvf;
    e.txDone  = mDoneEvt;
    e.txDrop  = mDropEvt;
    e.doneCnt = mDone;
    e.failCnt = mFail;
    e.frame   = mStaged;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit holdRst, input bit tv, input frame_t f,
                               input bit req, input bit retx, input bit dor,
                               input logic [63:0] rxp, input bit rdy, input bit clr);
    @(posedge clock);
    #1;
    if (!reset) modelReset();
    else        modelStep();
    if (holdRst) begin
      reset = 1'b0;
      modelReset();
    end else begin
      reset = 1'b1;
    end
    pushExp();
    tx_valid     = tv;
    tx_id        = f.id;
    tx_dest      = f.dest;
    tx_data      = f.data;
    data_in_req  = req;
    Retransmit   = retx;
    data_out_req = dor;
    Rx_packet    = rxp;
    rx_ready     = rdy;
    rx_ovf_clr   = clr;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic pushFrame(input frame_t f);
    applyStimulus(1'b0, 1'b1, f, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic nodeCycle(input bit req, input bit retx);
    applyStimulus(1'b0, 1'b0, '0, req, retx, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  function automatic frame_t randFrame();
    frame_t f;
    f.id   = 11'($urandom());
    f.dest = 11'($urandom());
    f.data = {$urandom(), $urandom()};
    return f;
  endfunction

  // Monitor: one prediction per edge, plus payload checks on each RX pop.
  initial begin
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        checkOutput("tx_avail",    64'(tx_avail),    64'(monE.txAvail));
        checkOutput("tx_ready",    64'(tx_ready),    64'(monE.txReady));
        checkOutput("rx_valid",    64'(rx_valid),    64'(monE.rxValid));
        checkOutput("rx_overflow", 64'(rx_overflow), 64'(monE.ovf));
        checkOutput("tx_done",     64'(tx_done),     64'(monE.txDone));
        checkOutput("tx_drop",     64'(tx_drop),     64'(monE.txDrop));
        checkOutput("done_cnt",    64'(done_cnt),    64'(monE.doneCnt));
        checkOutput("fail_cnt",    64'(fail_cnt),    64'(monE.failCnt));
        checkOutput("Tx_ID",       64'(Tx_ID),       64'(monE.frame.id));
        checkOutput("Rx_ID",       64'(Rx_ID),       64'(monE.frame.dest));
        checkOutput("In_packet",   In_packet,        monE.frame.data);
      end
      if (rx_valid && rx_ready) begin
        if (expRxData.size() == 0) checkOutput("rx_unexpected_pop", 64'd1, 64'd0);
        else                       checkOutput("rx_data", rx_data, expRxData.pop_front());
      end
    end
  end

  initial begin
    frame_t f;
    int     retxPct;
    reset        = 1'b0;
    tx_valid     = 1'b0;
    tx_id        = '0;
    tx_dest      = '0;
    tx_data      = '0;
    data_in_req  = 1'b0;
    Retransmit   = 1'b0;
    data_out_req = 1'b0;
    Rx_packet    = '0;
    rx_ready     = 1'b0;
    rx_ovf_clr   = 1'b0;
    modelReset();

    $display("[TB] reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    idleCycle();

    $display("[TB] single frame issue and success");
    pushFrame({11'h001, 11'h7FF, 64'hFFFFEEEE0000FEF1});
    nodeCycle(1'b1, 1'b0);
    idleCycle();
    nodeCycle(1'b1, 1'b0);
    idleCycle();

    $display("[TB] three retransmits then success");
    pushFrame({11'h123, 11'h456, 64'h0123456789ABCDEF});
    nodeCycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nodeCycle(1'b0, 1'b1);
      nodeCycle(1'b1, 1'b0);
    end
    nodeCycle(1'b1, 1'b0);
    idleCycle();

    $display("[TB] retry budget exhausted");
    pushFrame({11'h2AA, 11'h155, 64'hDEADBEEFCAFEF00D});
    nodeCycle(1'b1, 1'b0);
    for (int i = 0; i < MAXR; i++) begin
      nodeCycle(1'b0, 1'b1);
      if (i < MAXR - 1) nodeCycle(1'b1, 1'b0);
    end
    idleCycle();
    idleCycle();

    $display("[TB] TX queue fill and order");
    for (int i = 0; i < 5; i++) pushFrame({11'(i + 16), 11'(i + 32), 64'(i) * 64'h1111});
    idleCycle();
    for (int i = 0; i < 6; i++) nodeCycle(1'b1, 1'b0);
    idleCycle();

    $display("[TB] RX overflow and drain");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hA5A50000_00000000 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    idleCycle();

    $display("[TB] reset while a frame is in flight");
    for (int i = 0; i < 3; i++) pushFrame(randFrame());
    nodeCycle(1'b1, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    nodeCycle(1'b1, 1'b0);
    nodeCycle(1'b1, 1'b0);
    idleCycle();

    $display("[TB] randomized traffic");
    retxPct = 25;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) retxPct = (i % 400 == 0) ? 25 : 80;
      if ($urandom_range(0, 499) == 0) begin
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
      end else begin
        f = randFrame();
        applyStimulus(1'b0,
                      ($urandom_range(0, 99) < 40),
                      f,
                      ($urandom_range(0, 99) < 35),
                      ($urandom_range(0, 99) < retxPct),
                      ($urandom_range(0, 99) < 40),
                      {$urandom(), $urandom()},
                      ($urandom_range(0, 99) < 40),
                      ($urandom_range(0, 99) < 10));
      end
    end

    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    @(negedge clock);
    #1;
    checkOutput("rx_pending_payloads", 64'(expRxData.size()), 64'd0);
    checkOutput("pending_predictions", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/can_host_mailbox.md
# can_host_mailbox

Host-side message mailbox that answers a `can` node's host handshake. It queues outgoing frames (ID, destination filter ID and payload) and hands one to the node on each `data_in_req`. It re-presents the same frame after `Retransmit` and buffers frames the node delivers on `data_out_req` until the host drains them. One instance sits beside each `can` node, replacing bench-driven stimulus.

## Interface
Parameters:
- `DATA_SIZE`, 64: payload width (from `def.pkg`).
- `ID_SIZE`, 11: identifier width (from `def.pkg`).
- `TX_DEPTH`, 4: TX queue entries (power of 2, ≥2).
- `RX_DEPTH`, 4: RX queue entries (power of 2, ≥2).
- `MAX_RETRY`, 8: attempts per frame before it is dropped (≥1).

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_valid` / `tx_ready`  in/out  1  host push handshake; `tx_ready` = TX queue not full.
- `tx_id` / `tx_dest` / `tx_data`  in  ID_SIZE/ID_SIZE/DATA_SIZE  frame to queue.
- `data_in_req`  in  1  node requests next frame.
- `Retransmit`  in  1  node reports last issued frame failed.
- `In_packet` / `Tx_ID` / `Rx_ID`  out  DATA_SIZE/ID_SIZE/ID_SIZE  frame handed to node.
- `tx_avail`  out  1  a new or retry frame is ready for the node.
- `data_out_req`  in  1  node delivers a received frame on `Rx_packet`.
- `Rx_packet`  in  DATA_SIZE  received payload.
- `rx_valid` / `rx_ready` / `rx_data`  out/in/out  1/1/DATA_SIZE  host pop handshake.
- `rx_overflow`  out  1  sticky; a received frame was dropped.
- `rx_ovf_clr`  in  1  clears `rx_overflow`.
- `tx_done` / `tx_drop`  out  1  one-cycle pulses: frame succeeded, or dropped after `MAX_RETRY` attempts.
- `done_cnt` / `fail_cnt`  out  16  saturating success count and `Retransmit` count.

## Operation
- TX FSM states:
  - `IDLE`: no frame outstanding.
  - `ISSUED`: frame handed to node, outcome pending.
  - `RETRY`: failed frame held for re-issue.
- `IDLE` + `data_in_req`:
  - TX queue non-empty: pop head into staging, load `retry_cnt`=0, go to `ISSUED`.
  - Queue empty: request ignored, outputs hold.
- `ISSUED` + `data_in_req`, no `Retransmit`: the previous frame succeeded.
  - Pulse `tx_done` and increment `done_cnt`.
  - Queue non-empty: pop next frame into staging, stay in `ISSUED`.
  - Queue empty: go to `IDLE`.
- `ISSUED` + `Retransmit`:
  - Increment `fail_cnt` and `retry_cnt`.
  - If `retry_cnt`+1 == `MAX_RETRY`: pulse `tx_drop`, go to `IDLE`.
  - Otherwise go to `RETRY`; staging is unchanged.
- `RETRY` + `data_in_req`: re-present the staged frame unchanged, go to `ISSUED`.
- `Retransmit` and `data_in_req` in the same cycle while in `ISSUED`:
  - `Retransmit` is processed first.
  - If the frame is not dropped, the request re-issues it and the FSM stays in `ISSUED`.
  - If the frame is dropped, the request is handled as in `IDLE`.
- `Retransmit` in `IDLE` or `RETRY` is ignored.
- `tx_avail` = (state==`RETRY`) or TX queue non-empty.
- RX path:
  - `data_out_req` pushes `Rx_packet` into the RX queue.
  - If the RX queue is full, the frame is dropped and `rx_overflow` is set.
  - `rx_overflow` clears only on `rx_ovf_clr` or reset. A set and a clear in the same cycle leave it set.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: all outputs 0, FSM in `IDLE`, both queues empty. `tx_ready`=1 after reset.
- `data_in_req` sampled at edge N: `In_packet`/`Tx_ID`/`Rx_ID` are registered and valid from N+1. They hold until the next accepted `data_in_req`.
- `tx_done`/`tx_drop` pulse in the cycle after the deciding edge.
- Host push at N: the entry is visible to `tx_avail` at N+1.
- TX push on a full queue is not accepted, even if a pop occurs in the same cycle.
- `data_out_req` at N: `rx_valid` is high from N+1. `rx_data` shows the queue head (first-word fall-through).
- Simultaneous RX push and pop on a full queue: the pop happens and the push is dropped, setting `rx_overflow`.
- Reset asserted mid-frame: the staged frame and both queues are discarded. No `tx_done`/`tx_drop` pulse is generated.

## Structure
- `def.pkg` gains:
  - the `mbx_state_e` enum (`IDLE`, `ISSUED`, `RETRY`);
  - the `tx_entry_t` packed struct {id, dest, data};
  - defaults for `TX_DEPTH`, `RX_DEPTH`, `MAX_RETRY`.
- One sub-module, `can_msg_fifo`: a parameterized synchronous FWFT FIFO (width, depth) with full/empty flags. Instantiated twice: TX with `tx_entry_t`, RX with `DATA_SIZE`.

## Test plan
- Push `{11'h001, 11'h7FF, 64'hFFFFEEEE0000FEF1}`, then pulse `data_in_req` → `Tx_ID`=001, `Rx_ID`=7FF, `In_packet` correct at N+1. A second `data_in_req` pulses `tx_done` and `done_cnt`=1.
- Push one frame, issue it, then pulse `Retransmit` 3 times, each followed by `data_in_req` → identical frame re-presented each time, `fail_cnt`=3, no `tx_drop`.
- `MAX_RETRY`=2: issue, `Retransmit`, reissue, `Retransmit` → `tx_drop` pulse, FSM in `IDLE`, `tx_avail`=0.
- Push 5 frames with `TX_DEPTH`=4 → 5th push stalls (`tx_ready`=0). Frames are then issued in FIFO order.
- Drive 5 `data_out_req` with `rx_ready`=0, then drain → 4 payloads returned in order, `rx_overflow`=1. `rx_ovf_clr` clears it.
- Assert `reset` low while in `ISSUED` with 2 frames queued → all outputs 0, `tx_avail`=0, no `tx_done` after release.
